// File: rtl/xaddrgen_nd_if.sv
// xaddrgen_nd_if: configuration, control and memory-port signals of the nested-loop address generator
interface xaddrgen_nd_if #(parameter int LOOPS = 6, parameter int ADDR_W = 10, parameter int PERIOD_W = 10);
  logic run, pause, abort;
  logic [ADDR_W-1:0] start;
  logic [PERIOD_W-1:0] delay, duty;
  logic [LOOPS*ADDR_W-1:0] iter_flat, incr_flat;
  logic [ADDR_W-1:0] addr;
  logic mem_en, last, done;
  modport master(output run, pause, abort, start, delay, duty, iter_flat, incr_flat, input addr, mem_en, last, done);
  modport slave(input run, pause, abort, start, delay, duty, iter_flat, incr_flat, output addr, mem_en, last, done);
endinterface

// File: rtl/xaddrgen_nd.sv
// xaddrgen_nd: N-level nested-loop address generator with duty window, stall, abort and last flag
module xaddrgen_nd #(parameter int LOOPS = 6, parameter int ADDR_W = 10, parameter int PERIOD_W = 10) (
  input logic clk,
  input logic rst,
  xaddrgen_nd_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DELAY, RUN} state_t;
  state_t state, state_nx;
  logic [LOOPS-1:0][ADDR_W-1:0] c, b, lim, inc, nc, nb, lim_in, iter_in;
  logic [LOOPS-1:0] can, low, lm, nfull, ifull;
  logic [ADDR_W-1:0] nbv;
  logic [PERIOD_W-1:0] duty_r, dcnt;
  logic held, fin, nlast, ilast, accept, mem_en, last, done;
  function automatic logic below(input logic [ADDR_W-1:0] x, input logic [PERIOD_W-1:0] d);
    return {{PERIOD_W{1'b0}}, x} < {{ADDR_W{1'b0}}, d};
  endfunction
  assign iter_in = bus.iter_flat;
  assign bus.addr = b[0];
  assign bus.mem_en = mem_en;
  assign bus.last = last;
  assign bus.done = done;
  // limits are stored as iter-1, with zero counts on outer levels folded to one
  always_comb begin
    for (int k = 0; k < LOOPS; k++) begin
      lim_in[k] = (k > 0 && iter_in[k] == '0) ? '0 : iter_in[k] - ADDR_W'(1);
      ifull[k] = lim_in[k] == '0;
    end
    ilast = &ifull;
  end
  // the lowest level that can still count steps; every level below it restarts from its new base
  always_comb begin
    for (int k = 0; k < LOOPS; k++) can[k] = c[k] < lim[k];
    fin = ~|can;
    low = can & (~can + LOOPS'(1));
    lm = low - LOOPS'(1);
    nbv = '0;
    for (int k = 0; k < LOOPS; k++) if (low[k]) nbv = b[k] + inc[k];
    for (int j = 0; j < LOOPS; j++) begin
      nc[j] = lm[j] ? '0 : low[j] ? c[j] + ADDR_W'(1) : c[j];
      nb[j] = (lm[j] | low[j]) ? nbv : b[j];
      nfull[j] = !(nc[j] < lim[j]);
    end
    nlast = &nfull;
  end
  always_comb begin
    state_nx = state;
    accept = 1'b0;
    if (bus.abort) state_nx = IDLE;
    else if (state == IDLE && bus.run) begin
      accept = 1'b1;
      state_nx = iter_in[0] == '0 ? IDLE : bus.delay == '0 ? RUN : DELAY;
    end
    else if (state == DELAY && dcnt <= PERIOD_W'(1)) state_nx = RUN;
    else if (state == RUN && !bus.pause && !held && fin) state_nx = IDLE;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= state_nx;
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      c <= '0;
      b <= '0;
      lim <= '0;
      inc <= '0;
      duty_r <= '0;
      dcnt <= '0;
      held <= 1'b0;
      mem_en <= 1'b0;
      last <= 1'b0;
      done <= 1'b1;
    end else if (bus.abort) begin
      held <= 1'b0;
      mem_en <= 1'b0;
      last <= 1'b0;
      done <= 1'b1;
    end else if (accept) begin
      lim <= lim_in;
      inc <= bus.incr_flat;
      duty_r <= bus.duty;
      dcnt <= bus.delay;
      c <= '0;
      b <= {LOOPS{bus.start}};
      held <= 1'b0;
      done <= 1'b0;
      mem_en <= state_nx == RUN && bus.duty != '0;
      last <= state_nx == RUN && ilast;
    end else if (state == IDLE) begin
      done <= 1'b1;
      mem_en <= 1'b0;
      last <= 1'b0;
    end else if (state == DELAY) begin
      dcnt <= dcnt - PERIOD_W'(1);
      mem_en <= state_nx == RUN && below(c[0], duty_r);
      last <= state_nx == RUN && fin;
    end else if (bus.pause) begin
      held <= 1'b1;
      mem_en <= 1'b0;
      last <= 1'b0;
    end else if (held) begin
      held <= 1'b0;
      mem_en <= below(c[0], duty_r);
      last <= fin;
    end else if (fin) begin
      done <= 1'b1;
      mem_en <= 1'b0;
      last <= 1'b0;
    end else begin
      c <= nc;
      b <= nb;
      mem_en <= below(nc[0], duty_r);
      last <= nlast;
    end
  end
endmodule

// File: tb/tb_xaddrgen_nd.sv
// tb_xaddrgen_nd: directed checks of the nested-loop address generator
module tb_xaddrgen_nd;
  logic clk = 1'b0;
  logic rst = 1'b0;
  int checks = 0;
  int failures = 0;
  logic [5:0][9:0] it, inc;
  xaddrgen_nd_if bus();
  assign bus.iter_flat = it;
  assign bus.incr_flat = inc;
  xaddrgen_nd dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s got=%0d expected=%0d", t, got, exp);
    end
  endtask
  task automatic ex(input string t, input int a, input int en, input int l, input int d);
    chk({t, ".addr"}, 32'(bus.addr), a);
    chk({t, ".mem_en"}, 32'(bus.mem_en), en);
    chk({t, ".last"}, 32'(bus.last), l);
    chk({t, ".done"}, 32'(bus.done), d);
    @(negedge clk);
  endtask
  task automatic go;
    bus.run = 1'b1;
    @(negedge clk);
    bus.run = 1'b0;
  endtask
  task automatic cfg(input int s, input int d, input int du, input int i0, input int i1, input int n0, input int n1);
    bus.start = 10'(s);
    bus.delay = 10'(d);
    bus.duty = 10'(du);
    for (int k = 0; k < 6; k++) begin
      it[k] = 10'd1;
      inc[k] = 10'd0;
    end
    it[0] = 10'(i0);
    it[1] = 10'(i1);
    inc[0] = 10'(n0);
    inc[1] = 10'(n1);
  endtask
  task automatic nest(input string t);
    go;
    ex(t, 100, 1, 0, 0);
    ex(t, 101, 1, 0, 0);
    ex(t, 110, 1, 0, 0);
    ex(t, 111, 1, 0, 0);
    ex(t, 120, 1, 0, 0);
    ex(t, 121, 1, 1, 0);
    ex(t, 121, 0, 0, 1);
  endtask
  initial begin
    bus.run = 1'b0;
    bus.pause = 1'b0;
    bus.abort = 1'b0;
    cfg(0, 0, 0, 1, 1, 0, 0);
    @(negedge clk);
    ex("reset", 0, 0, 0, 1);
    rst = 1'b1;
    @(negedge clk);
    cfg(100, 0, 1023, 2, 3, 1, 10);
    nest("nest");
    it[3] = 10'd0;
    nest("iter3_zero");
    cfg(100, 0, 1023, 2, 3, 1, 10);
    go;
    ex("pause", 100, 1, 0, 0);
    ex("pause", 101, 1, 0, 0);
    bus.pause = 1'b1;
    ex("pause", 110, 1, 0, 0);
    bus.pause = 1'b0;
    ex("pause", 110, 0, 0, 0);
    ex("pause", 110, 1, 0, 0);
    ex("pause", 111, 1, 0, 0);
    ex("pause", 120, 1, 0, 0);
    ex("pause", 121, 1, 1, 0);
    ex("pause", 121, 0, 0, 1);
    cfg(0, 0, 1, 4, 2, 1, 4);
    go;
    for (int a = 0; a < 8; a++) ex("duty", a, int'(a == 0 || a == 4), int'(a == 7), 0);
    ex("duty", 7, 0, 0, 1);
    cfg(55, 3, 1023, 1, 1, 0, 0);
    go;
    bus.pause = 1'b1;
    ex("delay", 55, 0, 0, 0);
    ex("delay", 55, 0, 0, 0);
    bus.pause = 1'b0;
    ex("delay", 55, 0, 0, 0);
    ex("delay", 55, 1, 1, 0);
    ex("delay", 55, 0, 0, 1);
    cfg(7, 0, 1023, 0, 1, 0, 0);
    go;
    ex("iter0_zero", 7, 0, 0, 0);
    ex("iter0_zero", 7, 0, 0, 1);
    cfg(2, 0, 1023, 4, 1, 1023, 0);
    go;
    ex("wrap", 2, 1, 0, 0);
    ex("wrap", 1, 1, 0, 0);
    ex("wrap", 0, 1, 0, 0);
    ex("wrap", 1023, 1, 1, 0);
    ex("wrap", 1023, 0, 0, 1);
    cfg(100, 0, 1023, 2, 3, 1, 10);
    go;
    ex("abort", 100, 1, 0, 0);
    ex("abort", 101, 1, 0, 0);
    bus.abort = 1'b1;
    ex("abort", 110, 1, 0, 0);
    bus.abort = 1'b0;
    ex("abort", 110, 0, 0, 1);
    go;
    ex("restart", 100, 1, 0, 0);
    ex("restart", 101, 1, 0, 0);
    ex("restart", 110, 1, 0, 0);
    ex("restart", 111, 1, 0, 0);
    ex("restart", 120, 1, 0, 0);
    ex("restart", 121, 1, 1, 0);
    chk("b2b.done", 32'(bus.done), 1);
    go;
    ex("b2b", 100, 1, 0, 0);
    #2 rst = 1'b0;
    #1;
    chk("async_rst.addr", 32'(bus.addr), 0);
    chk("async_rst.mem_en", 32'(bus.mem_en), 0);
    chk("async_rst.last", 32'(bus.last), 0);
    chk("async_rst.done", 32'(bus.done), 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    ex("post_rst", 0, 0, 0, 1);
    ex("post_rst", 0, 0, 0, 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
